fc_requant_unit: RTL and testbench
==================================

Name: fc_requant_unit

Overview:
Downstream stage of fully_connected_unit. Consumes the signed int32 accumulator stream (bias already added) and applies TFLite per-tensor requantization: fixed-point multiply, rounding shift, output zero-point add and activation clamp. Emits a signed int8 stream toward the output writer. Job control uses start/ready/done, mirroring the FC unit.

Parameters:
OUT_W, 8, output element width (signed)
CNT_W, 16, element-count width (matches FC output_size field)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  job start pulse; sampled only in IDLE
count  in  CNT_W  number of elements in the job; latched on start
multiplier  in  32  Q31 quantized multiplier (signed); latched on start
shift  in  6  signed shift (>0 left, <0 right); latched on start
out_zero_point  in  16  signed output zero point; latched on start
act_min  in  OUT_W  signed clamp low; latched on start
act_max  in  OUT_W  signed clamp high; latched on start
acc_valid  in  1  input element valid
acc_ready  out  1  input element accepted when acc_valid&&acc_ready
acc_data  in  32  signed accumulator
out_valid  out  1  output element valid
out_ready  in  1  downstream ready
out_data  out  OUT_W  signed requantized element
ready  out  1  high in IDLE
done  out  1  one-cycle pulse at job end

Behaviour:
- Interface: one clock (clk); reset synchronous, active-high (rst).
- Reset: FSM=IDLE, ready=1, done=0, acc_ready=0, out_valid=0, out_data=0, all counters and pipeline valids 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: on start, latch config and clear in_cnt/out_cnt. Go to DONE if count==0, else RUN.
  - RUN: acc_ready = adv && (in_cnt<count). Go to DRAIN when the last input is accepted.
  - DRAIN: acc_ready=0. Go to DONE when out_cnt reaches count (last output handshake).
  - DONE: done=1 for one cycle, then IDLE.
  - start outside IDLE is ignored. Config inputs are ignored except at start.
- Pipeline: 3 stages, S1/S2/S3. Global advance adv = !S3.valid || out_ready.
  - When adv=0, every stage holds. The out_data/out_valid registers are S3.
  - Latency: 3 cycles from input handshake to out_valid with out_ready held high. Throughput is 1 element/cycle.
  - out_data stays stable while out_valid && !out_ready.
- Arithmetic (bit-exact to TFLite MultiplyByQuantizedMultiplier):
  - left = max(shift,0); right = max(-shift,0).
  - S1: x = acc << left, saturated to int32. Form the 64-bit signed product p = x*multiplier.
  - S2: if x==multiplier==INT32_MIN, h = INT32_MAX. Otherwise nudge = p>=0 ? 2^30 : 1-2^30, and h = (p+nudge)/2^31 truncated toward zero.
  - S3: mask = 2^right-1; rem = h&mask; thr = (mask>>1) + (h<0); r = (h>>>right) + (rem>thr).
  - Then v = r + out_zero_point in 33-bit signed, clamped to [act_min, act_max], truncated to OUT_W.
- act_min > act_max: output equals act_max (clamp-high applied last).
- rst mid-job: immediate return to IDLE. Pipeline contents are discarded; no done pulse.

Optional Feature:
REQUANT_SAT_COUNT_EN
- Defined: adds output port sat_count [CNT_W-1:0]. It counts elements whose pre-clamp value v fell outside [act_min, act_max]. Cleared on start and on rst, saturates at all-ones, and holds its value after done.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
1. mult=0x40000000, shift=0, zp=0, clamp [-128,127], count=3, inputs 100, 101, -101 with out_ready=1 -> outputs 50, 51, -50. First out_valid comes 3 cycles after the first accept; done pulses once after the third output.
2. mult=0x40000000, shift=-2, zp=-128, input 1000 -> 500 after S2, 125 after S3, out_data=-3.
3. Saturation: mult=0x7FFFFFFF, shift=0, clamp [-128,127]:
   - input 1000 -> 127.
   - input INT32_MIN with mult=INT32_MIN -> h=INT32_MAX -> 127.
   - input 0x40000000 with shift=+2 -> x saturates to INT32_MAX -> 127.
   - With REQUANT_SAT_COUNT_EN defined, sat_count=3.
4. Backpressure: count=8 with a continuous input stream, out_ready low for cycles 4-7 -> acc_ready drops within the same cycle adv falls. No element is lost or duplicated, outputs stay in order, and out_data stays stable while stalled.
5. count=0 -> done pulses 2 cycles after start, no acc_ready or out_valid assertion. A start pulse during RUN is ignored (count stays at the original value).
6. rst asserted mid-job after 2 of 5 inputs -> next cycle ready=1, out_valid=0, no done. A new job afterwards completes correctly.

Source files
------------

// File: rtl/fc_requant_unit.sv
// fc_requant_unit: TFLite per-tensor requantization of the FC int32 accumulator stream to int8.
// Optional feature macro REQUANT_SAT_COUNT_EN adds a per-job sat_count output of clamped elements.
module fc_requant_unit #(
  parameter int OUT_W = 8,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_W-1:0]        count,
  input  logic signed [31:0]      multiplier,
  input  logic signed [5:0]       shift,
  input  logic signed [15:0]      out_zero_point,
  input  logic signed [OUT_W-1:0] act_min,
  input  logic signed [OUT_W-1:0] act_max,
  input  logic                    acc_valid,
  output logic                    acc_ready,
  input  logic signed [31:0]      acc_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    ready,
  output logic                    done
`ifdef REQUANT_SAT_COUNT_EN
  ,
  output logic [CNT_W-1:0]        sat_count
`endif
);

  localparam logic signed [31:0] I32_MAX   = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] I32_MIN   = 32'sh8000_0000;
  localparam logic signed [63:0] I32_MAX64 = 64'sh0000_0000_7FFF_FFFF;
  localparam logic signed [63:0] I32_MIN64 = 64'shFFFF_FFFF_8000_0000;
  localparam logic signed [63:0] NUDGE_POS = 64'sh0000_0000_4000_0000;
  localparam logic signed [63:0] NUDGE_NEG = 64'shFFFF_FFFF_C000_0001;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]        cnt_q, in_cnt, out_cnt;
  logic signed [31:0]      mult_q;
  logic [4:0]              left_q;
  logic [5:0]              right_q;
  logic signed [15:0]      zp_q;
  logic signed [OUT_W-1:0] min_q, max_q;

  logic                    s1_valid, s1_special, s2_valid;
  logic signed [63:0]      s1_prod;
  logic signed [31:0]      s2_h;

  logic                    adv, in_fire, out_fire, start_fire;
  logic [4:0]              left_d;
  logic [5:0]              right_d;

  assign adv        = !out_valid || out_ready;
  assign acc_ready  = (state_q == RUN) && adv && (in_cnt < cnt_q);
  assign in_fire    = acc_valid && acc_ready;
  assign out_fire   = out_valid && out_ready;
  assign start_fire = (state_q == IDLE) && start;

  // The signed shift splits into a pre-multiply left shift and a post-multiply rounding right shift.
  assign left_d  = shift[5] ? 5'd0 : shift[4:0];
  assign right_d = shift[5] ? (~shift + 6'd1) : 6'd0;

  // S1 datapath: saturating left shift then full 64-bit product.
  logic signed [63:0] acc_shl, prod;
  logic signed [31:0] x_sat;
  logic               special;

  assign acc_shl = $signed({{32{acc_data[31]}}, acc_data}) <<< left_q;
  assign x_sat   = (acc_shl > I32_MAX64) ? I32_MAX :
                   (acc_shl < I32_MIN64) ? I32_MIN : acc_shl[31:0];
  assign prod    = $signed({{32{x_sat[31]}}, x_sat}) * $signed({{32{mult_q[31]}}, mult_q});
  assign special = (x_sat == I32_MIN) && (mult_q == I32_MIN);

  // S2 datapath: round-to-nearest doubling high multiply, quotient truncated toward zero.
  logic signed [63:0] nudge, sum, quot;
  logic signed [31:0] h;

  assign nudge = s1_prod[63] ? NUDGE_NEG : NUDGE_POS;
  assign sum   = s1_prod + nudge;
  assign quot  = sum[63] ? ((sum + I32_MAX64) >>> 31) : (sum >>> 31);
  assign h     = s1_special ? I32_MAX : quot[31:0];

  // S3 datapath: rounding divide by power of two, zero-point add, then clamp low before clamp high.
  logic signed [63:0]      h64, r64;
  logic [63:0]             mask, rem, thr;
  logic signed [32:0]      v, min33, max33, lo_v, cl_v;
  logic signed [OUT_W-1:0] out_d;

  assign h64   = $signed({{32{s2_h[31]}}, s2_h});
  assign mask  = (64'd1 << right_q) - 64'd1;
  assign rem   = h64 & mask;
  assign thr   = (mask >> 1) + {63'd0, s2_h[31]};
  assign r64   = (h64 >>> right_q) + ((rem > thr) ? 64'sd1 : 64'sd0);
  assign v     = $signed(r64[32:0]) + $signed({{17{zp_q[15]}}, zp_q});
  assign min33 = $signed({{(33-OUT_W){min_q[OUT_W-1]}}, min_q});
  assign max33 = $signed({{(33-OUT_W){max_q[OUT_W-1]}}, max_q});
  assign lo_v  = (v < min33) ? min33 : v;
  assign cl_v  = (lo_v > max33) ? max33 : lo_v;
  assign out_d = cl_v[OUT_W-1:0];

  logic unused_bits;
  assign unused_bits = ^{quot[63:32], r64[63:33], cl_v[32:OUT_W]};

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) state_d = (count == '0) ? DONE : RUN;
      end
      RUN:   if (in_fire && (in_cnt == cnt_q - CNT_W'(1))) state_d = DRAIN;
      DRAIN: if (out_fire && (out_cnt == cnt_q - CNT_W'(1))) state_d = DONE;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
      mult_q  <= '0;
      left_q  <= '0;
      right_q <= '0;
      zp_q    <= '0;
      min_q   <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start_fire) begin
        cnt_q   <= count;
        mult_q  <= multiplier;
        left_q  <= left_d;
        right_q <= right_d;
        zp_q    <= out_zero_point;
        min_q   <= act_min;
        max_q   <= act_max;
        in_cnt  <= '0;
        out_cnt <= '0;
      end else begin
        if (in_fire)  in_cnt  <= in_cnt + CNT_W'(1);
        if (out_fire) out_cnt <= out_cnt + CNT_W'(1);
      end
    end
  end

  // All three stages move together on adv; a stalled output freezes the whole pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_prod    <= '0;
      s1_special <= 1'b0;
      s2_valid   <= 1'b0;
      s2_h       <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else if (adv) begin
      s1_valid   <= in_fire;
      s1_prod    <= prod;
      s1_special <= special;
      s2_valid   <= s1_valid;
      s2_h       <= h;
      out_valid  <= s2_valid;
      if (s2_valid) out_data <= out_d;
    end
  end

`ifdef REQUANT_SAT_COUNT_EN
  logic s3_sat;
  assign s3_sat = (v < min33) || (v > max33);

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_count <= '0;
    end else if (start_fire) begin
      sat_count <= '0;
    end else if (adv && s2_valid && s3_sat && (sat_count != '1)) begin
      sat_count <= sat_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fc_requant_unit.sv
// tb_fc_requant_unit: directed table-driven bench for fc_requant_unit with a scoreboarded output monitor.
// Defining REQUANT_SAT_COUNT_EN also checks the sat_count port.
module tb_fc_requant_unit;
  localparam int OUT_W = 8;
  localparam int CNT_W = 16;
  localparam int NV    = 10;

  logic                    clk = 1'b0;
  logic                    rst, start;
  logic [CNT_W-1:0]        count;
  logic signed [31:0]      multiplier;
  logic signed [5:0]       shift;
  logic signed [15:0]      out_zero_point;
  logic signed [OUT_W-1:0] act_min, act_max;
  logic                    acc_valid, acc_ready;
  logic signed [31:0]      acc_data;
  logic                    out_valid, out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic                    ready, done;
`ifdef REQUANT_SAT_COUNT_EN
  logic [CNT_W-1:0]        sat_count;
`endif

  fc_requant_unit #(.OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .count(count), .multiplier(multiplier),
    .shift(shift), .out_zero_point(out_zero_point), .act_min(act_min), .act_max(act_max),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_data(acc_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ready(ready), .done(done)
`ifdef REQUANT_SAT_COUNT_EN
    , .sat_count(sat_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int              n;
    logic [31:0]     mult;
    logic [5:0]      sh;
    logic [15:0]     zp;
    logic [7:0]      amin;
    logic [7:0]      amax;
    logic [3:0][31:0] acc;
    logic [3:0][7:0] exp;
    int              sat;
  } vec_t;

  vec_t                    tbl [NV];
  logic signed [31:0]      in_vec [16];
  logic signed [OUT_W-1:0] exp_q [$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int first_out_cyc = -1;
  bit stalled = 1'b0;
  logic signed [OUT_W-1:0] held;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Output monitor: scoreboard order, stall stability and done pulse counting.
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        checkOutput("stall_valid_hold", longint'(out_valid), 1);
        checkOutput("stall_data_hold", longint'(out_data), longint'(held));
      end
      if (out_valid && !out_ready) checkOutput("acc_ready_in_stall", longint'(acc_ready), 0);
      if (out_valid && out_ready) begin
        if (first_out_cyc < 0) first_out_cyc = cyc;
        if (exp_q.size() == 0) checkOutput("unexpected_out", longint'(out_data), 9999);
        else checkOutput("out_data", longint'(out_data), longint'(exp_q.pop_front()));
      end
      if (done) done_cnt++;
      stalled = out_valid && !out_ready;
      held    = out_data;
    end
  end

  task automatic addVec(input int i, input int n, input logic [31:0] m, input logic [5:0] sh,
                        input logic [15:0] zp, input logic [7:0] lo, input logic [7:0] hi,
                        input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                        input logic [31:0] a3, input logic [7:0] e0, input logic [7:0] e1,
                        input logic [7:0] e2, input logic [7:0] e3, input int sat);
    tbl[i].n = n;  tbl[i].mult = m;  tbl[i].sh = sh;  tbl[i].zp = zp;
    tbl[i].amin = lo;  tbl[i].amax = hi;  tbl[i].sat = sat;
    tbl[i].acc[0] = a0; tbl[i].acc[1] = a1; tbl[i].acc[2] = a2; tbl[i].acc[3] = a3;
    tbl[i].exp[0] = e0; tbl[i].exp[1] = e1; tbl[i].exp[2] = e2; tbl[i].exp[3] = e3;
  endtask

  // Runs one job from in_vec; optional stall window, mid-run start pulse, or abort after N accepts.
  task automatic applyStimulus(input int n, input logic [31:0] m, input logic [5:0] sh,
                               input logic [15:0] zp, input logic [7:0] lo, input logic [7:0] hi,
                               input int stall_lo, input int stall_hi, input int restart_at,
                               input int abort_after, input bit chk_lat);
    int idx = 0;
    int acc_cyc = -1;
    int start_cyc, done_cyc;
    bit seen_done = 1'b0;
    done_cyc = -1;
    first_out_cyc = -1;
    @(posedge clk); #1;
    done_cnt = 0;
    start = 1'b1; count = CNT_W'(n); multiplier = m; shift = sh;
    out_zero_point = zp; act_min = lo; act_max = hi;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 0; t < 300 && !seen_done; t++) begin
      acc_valid = (idx < n);
      acc_data  = in_vec[(idx < n) ? idx : 0];
      out_ready = !(t >= stall_lo && t <= stall_hi);
      start     = (t == restart_at);
      if (t == restart_at) begin
        count = CNT_W'(1); multiplier = 32'h7FFF_FFFF;
      end
      @(negedge clk);
      if (n == 0) begin
        checkOutput("cnt0_acc_ready", longint'(acc_ready), 0);
        checkOutput("cnt0_out_valid", longint'(out_valid), 0);
      end
      if (acc_valid && acc_ready) begin
        if (acc_cyc < 0) acc_cyc = cyc;
        idx++;
      end
      if (done) begin
        seen_done = 1'b1;
        done_cyc  = cyc;
      end
      if (abort_after >= 0 && idx == abort_after) return;
      @(posedge clk); #1;
    end
    acc_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
    checkOutput("done_seen", longint'(seen_done), 1);
    checkOutput("inputs_accepted", idx, n);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("done_pulses", done_cnt, 1);
    checkOutput("outputs_left", exp_q.size(), 0);
    checkOutput("ready_after_job", longint'(ready), 1);
    if (chk_lat && n > 0) checkOutput("latency", first_out_cyc - acc_cyc, 3);
    if (n == 0) checkOutput("cnt0_done_in_window",
                            longint'((done_cyc - start_cyc) >= 1 && (done_cyc - start_cyc) <= 2), 1);
    exp_q.delete();
  endtask

  initial begin
    addVec(0, 3, 32'h4000_0000, 6'sd0, 16'sd0, 8'h80, 8'h7F,
           32'sd100, 32'sd101, -32'sd101, 32'sd0, 8'sd50, 8'sd51, -8'sd50, 8'sd0, 0);
    addVec(1, 1, 32'h4000_0000, -6'sd2, -16'sd128, 8'h80, 8'h7F,
           32'sd1000, 32'sd0, 32'sd0, 32'sd0, -8'sd3, 8'sd0, 8'sd0, 8'sd0, 0);
    addVec(2, 3, 32'h7FFF_FFFF, 6'sd0, 16'sd0, 8'h80, 8'h7F,
           32'sd1000, 32'sd300, -32'sd1000, 32'sd0, 8'sd127, 8'sd127, 8'h80, 8'sd0, 3);
    addVec(3, 2, 32'h8000_0000, 6'sd0, 16'sd0, 8'h80, 8'h7F,
           32'h8000_0000, 32'sd2, 32'sd0, 32'sd0, 8'sd127, -8'sd2, 8'sd0, 8'sd0, 1);
    addVec(4, 2, 32'h7FFF_FFFF, 6'sd2, 16'sd0, 8'h80, 8'h7F,
           32'h4000_0000, 32'hC000_0000, 32'sd0, 32'sd0, 8'sd127, 8'h80, 8'sd0, 8'sd0, 2);
    addVec(5, 4, 32'h4000_0000, -6'sd1, 16'sd10, 8'h80, 8'h7F,
           32'sd6, 32'sd10, -32'sd6, -32'sd10, 8'sd12, 8'sd13, 8'sd8, 8'sd7, 0);
    addVec(6, 3, 32'h4000_0000, 6'sd0, 16'sd0, 8'sd10, -8'sd10,
           32'sd100, -32'sd100, 32'sd0, 32'sd0, -8'sd10, -8'sd10, -8'sd10, 8'sd0, 3);
    addVec(7, 3, 32'h4000_0000, 6'sd0, 16'sd100, 8'h80, 8'h7F,
           32'sd40, 32'sd60, -32'sd600, 32'sd0, 8'sd120, 8'sd127, 8'h80, 8'sd0, 2);
    addVec(8, 2, 32'h4000_0000, 6'sd3, 16'sd0, 8'h80, 8'h7F,
           32'sd5, -32'sd7, 32'sd0, 32'sd0, 8'sd20, -8'sd28, 8'sd0, 8'sd0, 0);
    addVec(9, 2, 32'h4000_0000, 6'h20, 16'sd7, 8'h80, 8'h7F,
           32'sd1000, -32'sd1000, 32'sd0, 32'sd0, 8'sd7, 8'sd7, 8'sd0, 8'sd0, 0);

    rst = 1'b1; start = 1'b0; count = '0; multiplier = '0; shift = '0;
    out_zero_point = '0; act_min = '0; act_max = '0;
    acc_valid = 1'b0; acc_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ready", longint'(ready), 1);
    checkOutput("reset_done", longint'(done), 0);
    checkOutput("reset_acc_ready", longint'(acc_ready), 0);
    checkOutput("reset_out_valid", longint'(out_valid), 0);
    checkOutput("reset_out_data", longint'(out_data), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        in_vec[k] = tbl[i].acc[k];
        exp_q.push_back(tbl[i].exp[k]);
      end
      applyStimulus(tbl[i].n, tbl[i].mult, tbl[i].sh, tbl[i].zp, tbl[i].amin, tbl[i].amax,
                    -1, -1, -1, -1, 1'b1);
`ifdef REQUANT_SAT_COUNT_EN
      checkOutput("sat_count", longint'(sat_count), tbl[i].sat);
`endif
    end

    // Backpressure: eight elements with out_ready low for four cycles.
    for (int k = 0; k < 8; k++) begin
      in_vec[k] = 32'(10 * (k + 1));
      exp_q.push_back(8'(5 * (k + 1)));
    end
    applyStimulus(8, 32'h4000_0000, 6'sd0, 16'sd0, 8'h80, 8'h7F, 4, 7, -1, -1, 1'b0);

    // Empty job, then a start pulse in RUN that must not relatch count or multiplier.
    applyStimulus(0, 32'h4000_0000, 6'sd0, 16'sd0, 8'h80, 8'h7F, -1, -1, -1, -1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      in_vec[k] = 32'(10 * (k + 1));
      exp_q.push_back(8'(5 * (k + 1)));
    end
    applyStimulus(4, 32'h4000_0000, 6'sd0, 16'sd0, 8'h80, 8'h7F, -1, -1, 1, -1, 1'b1);

    // Reset after two of five accepts; nothing may come out and no done may pulse.
    for (int k = 0; k < 5; k++) in_vec[k] = 32'(1000 + k);
    applyStimulus(5, 32'h4000_0000, 6'sd0, 16'sd0, 8'h80, 8'h7F, -1, -1, -1, 2, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1; acc_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    done_cnt = 0;
    @(negedge clk);
    checkOutput("rst_mid_ready", longint'(ready), 1);
    checkOutput("rst_mid_out_valid", longint'(out_valid), 0);
    checkOutput("rst_mid_done", longint'(done), 0);
    checkOutput("rst_mid_acc_ready", longint'(acc_ready), 0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("rst_mid_no_done", done_cnt, 0);
    checkOutput("rst_mid_no_output", longint'(out_valid), 0);

    in_vec[0] = 32'sd100; in_vec[1] = 32'sd101; in_vec[2] = -32'sd101;
    exp_q.push_back(8'sd50); exp_q.push_back(8'sd51); exp_q.push_back(-8'sd50);
    applyStimulus(3, 32'h4000_0000, 6'sd0, 16'sd0, 8'h80, 8'h7F, -1, -1, -1, -1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
